// File: rtl/case_4_sdiv_8s_5s_8_seq_pkg.sv
// Shared constants for the case_4 sequential signed divider:
// operand widths, iteration counter width and FSM state encodings.
package case_4_div_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 5;
  localparam int CNT_W      = $clog2(DIVIDEND_W);

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_FIX  = 2'd2;

endpackage

// File: rtl/case_4_sdiv_8s_5s_8_seq_if.sv
// Block-level start/done/idle bundle of the case_4 signed divider,
// carrying operands in and quotient/remainder/div-by-zero out.
interface case_4_sdiv_8s_5s_8_seq_if #(
  parameter int din0_WIDTH = 8,
  parameter int din1_WIDTH = 5,
  parameter int dout_WIDTH = 8
);
  logic                  ap_ce;
  logic                  ap_start;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  ap_idle;
  logic                  ap_done;
  logic [dout_WIDTH-1:0] dout_q;
  logic [din1_WIDTH-1:0] dout_r;
  logic                  div_by_zero;

  modport master (
    output ap_ce, ap_start, din0, din1,
    input  ap_idle, ap_done, dout_q, dout_r, div_by_zero
  );

  modport slave (
    input  ap_ce, ap_start, din0, din1,
    output ap_idle, ap_done, dout_q, dout_r, div_by_zero
  );
endinterface

// File: rtl/case_4_sdiv_8s_5s_8_seq_step.sv
// One restoring division step on unsigned magnitudes: shift the
// {remainder, dividend} pair left, try subtracting the divisor and keep
// the difference only when it does not go negative.
module case_4_sdiv_step
  import case_4_div_pkg::*;
#(
  parameter int DW = DIVIDEND_W,
  parameter int VW = DIVISOR_W
) (
  input  logic [VW:0]   rem_in,
  input  logic [DW-1:0] dvd_in,
  input  logic [VW-1:0] dvs,
  output logic [VW:0]   rem_out,
  output logic [DW-1:0] dvd_out
);

  logic [VW+1:0] sh;
  logic          take;

  // Shift in the next dividend bit, trial-subtract, select restore or keep
  always_comb begin
    sh      = {rem_in, dvd_in[DW-1]};
    take    = (sh >= {2'b00, dvs});
    rem_out = take ? (VW+1)'(sh - {2'b00, dvs}) : sh[VW:0];
    dvd_out = {dvd_in[DW-2:0], take};
  end

endmodule

// File: rtl/case_4_sdiv_8s_5s_8_seq.sv
// Sequential signed divider for the case_4 kernel: one quotient bit per
// clock-enabled cycle, then a single sign-fixup cycle. Quotient truncates
// toward zero and the remainder follows the dividend's sign.
module case_4_sdiv_8s_5s_8_seq
  import case_4_div_pkg::*;
#(
  parameter int ID         = 1,
  parameter int din0_WIDTH = DIVIDEND_W,
  parameter int din1_WIDTH = DIVISOR_W,
  parameter int dout_WIDTH = DIVIDEND_W
) (
  input logic                       ap_clk,
  input logic                       ap_rst,
  case_4_sdiv_8s_5s_8_seq_if.slave  bus
);

  localparam int CW = (din0_WIDTH > 1) ? $clog2(din0_WIDTH) : 1;

  if (dout_WIDTH != din0_WIDTH || ID < 0) begin : g_bad_cfg
    $error("case_4_sdiv_8s_5s_8_seq: dout_WIDTH must equal din0_WIDTH");
  end

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [din0_WIDTH-1:0] dvd;
  logic [din1_WIDTH-1:0] dvs;
  logic [din1_WIDTH:0]   rem;
  logic                  sign_q;
  logic                  sign_r;
  logic [din0_WIDTH-1:0] dvd_nxt;
  logic [din1_WIDTH:0]   rem_nxt;
  logic [din0_WIDTH-1:0] mag0;
  logic [din1_WIDTH-1:0] mag1;
  logic                  done;
  logic [dout_WIDTH-1:0] q_reg;
  logic [din1_WIDTH-1:0] r_reg;
  logic                  dbz;

  function automatic logic [dout_WIDTH-1:0] fix_q(input logic neg,
                                                  input logic [din0_WIDTH-1:0] m);
    return neg ? dout_WIDTH'(-m) : dout_WIDTH'(m);
  endfunction

  function automatic logic [din1_WIDTH-1:0] fix_r(input logic neg,
                                                  input logic [din1_WIDTH-1:0] m);
    return neg ? -m : m;
  endfunction

  // Magnitudes as unsigned, so the most negative value maps to 2^(W-1)
  assign mag0 = bus.din0[din0_WIDTH-1] ? -bus.din0 : bus.din0;
  assign mag1 = bus.din1[din1_WIDTH-1] ? -bus.din1 : bus.din1;

  case_4_sdiv_step #(
    .DW (din0_WIDTH),
    .VW (din1_WIDTH)
  ) u_step (
    .rem_in  (rem),
    .dvd_in  (dvd),
    .dvs     (dvs),
    .rem_out (rem_nxt),
    .dvd_out (dvd_nxt)
  );

  // Control FSM, iteration counter and result registers
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      done  <= 1'b0;
      q_reg <= '0;
      r_reg <= '0;
      dbz   <= 1'b0;
    end else if (bus.ap_ce) begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ap_start) begin
            state <= S_CALC;
            cnt   <= CW'(din0_WIDTH - 1);
          end
        end
        S_CALC: begin
          if (cnt == '0) state <= S_FIX;
          else           cnt   <= cnt - 1'b1;
        end
        S_FIX: begin
          done  <= 1'b1;
          state <= S_IDLE;
          if (dvs == '0) begin
            q_reg <= '1;
            r_reg <= '0;
            dbz   <= 1'b1;
          end else begin
            q_reg <= fix_q(sign_q, dvd);
            r_reg <= fix_r(sign_r, rem[din1_WIDTH-1:0]);
            dbz   <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand capture on accept, then one restoring step per CALC cycle
  always_ff @(posedge ap_clk) begin
    if (bus.ap_ce) begin
      if (state == S_IDLE && bus.ap_start) begin
        dvd    <= mag0;
        dvs    <= mag1;
        rem    <= '0;
        sign_q <= bus.din0[din0_WIDTH-1] ^ bus.din1[din1_WIDTH-1];
        sign_r <= bus.din0[din0_WIDTH-1];
      end else if (state == S_CALC) begin
        dvd <= dvd_nxt;
        rem <= rem_nxt;
      end
    end
  end

  assign bus.ap_idle     = (state == S_IDLE);
  assign bus.ap_done     = done;
  assign bus.dout_q      = q_reg;
  assign bus.dout_r      = r_reg;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_case_4_sdiv_8s_5s_8_seq.sv
// Directed bench for the case_4 sequential signed divider.
module tb_case_4_sdiv_8s_5s_8_seq;

  logic ap_clk = 1'b0;
  logic ap_rst;
  int   total  = 0;
  int   passed = 0;
  int   lat;
  int   idle_hi;
  int   ndone;

  case_4_sdiv_8s_5s_8_seq_if #(
    .din0_WIDTH (8),
    .din1_WIDTH (5),
    .dout_WIDTH (8)
  ) bus ();

  case_4_sdiv_8s_5s_8_seq #(
    .ID         (1),
    .din0_WIDTH (8),
    .din1_WIDTH (5),
    .dout_WIDTH (8)
  ) dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_div(input logic [7:0] a, input logic [4:0] b);
    bus.din0     = a;
    bus.din1     = b;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
  endtask

  // Waits for ap_done (bounded); returns cycles waited and cycles idle was high
  task automatic wait_done(output int n, output int ih);
    n  = 0;
    ih = 0;
    while (bus.ap_done !== 1'b1 && n < 40) begin
      if (bus.ap_idle !== 1'b0) ih++;
      tick();
      n++;
    end
  endtask

  task automatic count_done(input int cycles, output int nd);
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.ap_done === 1'b1) nd++;
    end
  endtask

  initial begin
    ap_rst       = 1'b1;
    bus.ap_ce    = 1'b1;
    bus.ap_start = 1'b0;
    bus.din0     = '0;
    bus.din1     = '0;
    tick();
    tick();
    check("rst_idle", bus.ap_idle, 1);
    check("rst_done", bus.ap_done, 0);
    check("rst_q",    bus.dout_q, 8'h00);
    check("rst_r",    bus.dout_r, 5'h00);
    check("rst_dbz",  bus.div_by_zero, 0);
    ap_rst = 1'b0;
    tick();

    // 100 / 7
    start_div(8'd100, 5'd7);
    wait_done(lat, idle_hi);
    check("p7_lat",     lat, 9);
    check("p7_idlelow", idle_hi, 0);
    check("p7_idle",    bus.ap_idle, 1);
    check("p7_q",       bus.dout_q, 8'h0E);
    check("p7_r",       bus.dout_r, 5'h02);
    check("p7_dbz",     bus.div_by_zero, 0);

    // -100 / 7, started in the ap_done cycle
    start_div(8'h9C, 5'd7);
    check("b2b_done_drop", bus.ap_done, 0);
    wait_done(lat, idle_hi);
    check("n7_lat", lat, 9);
    check("n7_q",   bus.dout_q, 8'hF2);
    check("n7_r",   bus.dout_r, 5'h1E);
    tick();
    check("done_pulse", bus.ap_done, 0);

    // 127 / -16
    start_div(8'h7F, 5'h10);
    wait_done(lat, idle_hi);
    check("m16_q", bus.dout_q, 8'hF9);
    check("m16_r", bus.dout_r, 5'h0F);
    tick();

    // -128 / -1 wraps
    start_div(8'h80, 5'h1F);
    wait_done(lat, idle_hi);
    check("ovf_q", bus.dout_q, 8'h80);
    check("ovf_r", bus.dout_r, 5'h00);
    tick();

    // -128 / 5
    start_div(8'h80, 5'd5);
    wait_done(lat, idle_hi);
    check("m128_q", bus.dout_q, 8'hE7);
    check("m128_r", bus.dout_r, 5'h1D);
    tick();

    // 50 / 0
    start_div(8'd50, 5'd0);
    wait_done(lat, idle_hi);
    check("dz_lat", lat, 9);
    check("dz_q",   bus.dout_q, 8'hFF);
    check("dz_r",   bus.dout_r, 5'h00);
    check("dz_flag", bus.div_by_zero, 1);
    start_div(8'd100, 5'd7);
    wait_done(lat, idle_hi);
    check("dz_clear", bus.div_by_zero, 0);
    check("dz_next_q", bus.dout_q, 8'h0E);
    tick();

    // Busy start at iteration 3 is ignored
    start_div(8'd100, 5'd7);
    tick();
    tick();
    bus.din0     = 8'd10;
    bus.din1     = 5'd3;
    bus.ap_start = 1'b1;
    tick();
    bus.ap_start = 1'b0;
    wait_done(lat, idle_hi);
    check("busy_lat", lat, 6);
    check("busy_q",   bus.dout_q, 8'h0E);
    check("busy_r",   bus.dout_r, 5'h02);
    count_done(12, ndone);
    check("busy_single_done", ndone, 0);

    // ap_ce low for 3 cycles mid-CALC
    start_div(8'h9C, 5'd7);
    tick();
    tick();
    bus.ap_ce = 1'b0;
    tick();
    tick();
    tick();
    bus.ap_ce = 1'b1;
    wait_done(lat, idle_hi);
    check("ce_lat", lat + 5, 12);
    check("ce_q",   bus.dout_q, 8'hF2);
    check("ce_r",   bus.dout_r, 5'h1E);
    bus.ap_ce = 1'b0;
    tick();
    check("ce_done_hold", bus.ap_done, 1);
    bus.ap_ce = 1'b1;
    tick();
    check("ce_done_fall", bus.ap_done, 0);

    // Reset at iteration 4, with ce low to show reset priority
    start_div(8'd100, 5'd7);
    tick();
    tick();
    tick();
    ap_rst    = 1'b1;
    bus.ap_ce = 1'b0;
    tick();
    ap_rst    = 1'b0;
    bus.ap_ce = 1'b1;
    check("mrst_idle", bus.ap_idle, 1);
    check("mrst_q",    bus.dout_q, 8'h00);
    check("mrst_r",    bus.dout_r, 5'h00);
    check("mrst_done", bus.ap_done, 0);
    count_done(15, ndone);
    check("mrst_no_done", ndone, 0);

    // 7 / -2 after reset
    start_div(8'd7, 5'h1E);
    wait_done(lat, idle_hi);
    check("post_lat", lat, 9);
    check("post_q",   bus.dout_q, 8'hFD);
    check("post_r",   bus.dout_r, 5'h01);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
